// File: rtl/led_pattern_scheduler_pkg.sv
// Shared types, initial patterns and the per-mode step rule for the LED scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {CHASE, BOUNCE, FILL, BLINK} mode_t;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  localparam logic [7:0] INIT_CHASE  = 8'h01;
  localparam logic [7:0] INIT_BOUNCE = 8'h01;
  localparam logic [7:0] INIT_FILL   = 8'h00;
  localparam logic [7:0] INIT_BLINK  = 8'hFF;

  typedef struct packed {
    logic       dir;  // 1 = toward MSB (BOUNCE only)
    logic [7:0] led;
  } pat_t;

  function automatic logic [7:0] init_pattern(mode_t m);
    case (m)
      CHASE:   return INIT_CHASE;
      BOUNCE:  return INIT_BOUNCE;
      FILL:    return INIT_FILL;
      default: return INIT_BLINK;
    endcase
  endfunction

  function automatic pat_t next_pattern(mode_t m, logic [7:0] led, logic dir);
    pat_t p;
    p.dir = dir;
    p.led = led;
    case (m)
      CHASE:  p.led = {led[6:0], led[7]};
      BOUNCE: begin
        // Reversal happens on the end value itself so 0x80/0x01 never repeat.
        if (dir) begin
          if (led == 8'h80) begin p.dir = 1'b0; p.led = 8'h40; end
          else p.led = {led[6:0], 1'b0};
        end else begin
          if (led == 8'h01) begin p.dir = 1'b1; p.led = 8'h02; end
          else p.led = {1'b0, led[7:1]};
        end
      end
      FILL:    p.led = (led == 8'hFF) ? 8'h00 : {led[6:0], 1'b1};
      default: p.led = ~led;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_pattern_scheduler_if.sv
// Mode-request valid/ack handshake between the input pins and the scheduler.
interface led_pattern_scheduler_if;
  logic [1:0] mode_sel;
  logic       mode_valid;
  logic       mode_ack;

  modport master (output mode_sel, output mode_valid, input mode_ack);
  modport slave  (input mode_sel, input mode_valid, output mode_ack);
endinterface

// File: rtl/led_pattern_scheduler_tick_prescaler.sv
// Programmable prescaler: period latched from speed at wrap/clear, clamped to >= 1.
module tick_prescaler #(
  parameter logic [23:0] TICK_DIV = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       clear_i,
  input  logic [2:0] speed_i,
  output logic       adv_o
);

  localparam logic [23:0] RST_PERIOD = (TICK_DIV == 24'd0) ? 24'd1 : TICK_DIV;

  logic [23:0] count_q;
  logic [23:0] period_q;
  logic [23:0] period_d;

  always_comb begin
    period_d = TICK_DIV >> speed_i;
    if (period_d == 24'd0) period_d = 24'd1;
  end

  assign adv_o = run_i && (count_q >= period_q - 24'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      period_q <= RST_PERIOD;
    end else if (clear_i) begin
      count_q  <= '0;
      period_q <= period_d;
    end else if (run_i) begin
      if (adv_o) begin
        count_q  <= '0;
        period_q <= period_d;
      end else begin
        count_q <= count_q + 24'd1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_scheduler.sv
// LED bank controller: prescaled pattern stepping with tick-aligned mode switching.
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter logic [23:0] TICK_DIV = 24'd10_000_000,
  parameter int          LED_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  led_pattern_scheduler_if.slave  mode_if,
  input  logic [2:0]              speed,
  input  logic                    pause,
  input  logic                    step,
  output logic [LED_W-1:0]        led_out,
  output logic                    tick,
  output logic [1:0]              cur_mode
);

  state_t     state_q;
  mode_t      mode_q;
  logic [7:0] led_q;
  logic       dir_q;
  logic       tick_q;
  logic       ack_q;

  logic adv;
  logic run;
  logic clear;
  logic req;
  pat_t nxt;

  // ack_q gates req so one held request is acknowledged only once.
  assign req   = mode_if.mode_valid && !ack_q;
  assign run   = ena && (state_q == RUN) && !pause;
  assign clear = !ena || (state_q == IDLE) || (state_q == LOAD);
  assign nxt   = next_pattern(mode_q, led_q, dir_q);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_i   (run),
    .clear_i (clear),
    .speed_i (speed),
    .adv_o   (adv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= CHASE;
      led_q   <= '0;
      dir_q   <= 1'b1;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      ack_q  <= 1'b0;
      if (!ena) begin
        state_q <= IDLE;
        led_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            led_q <= '0;
            if (req) begin
              ack_q  <= 1'b1;
              mode_q <= mode_t'(mode_if.mode_sel);
            end
            state_q <= LOAD;
          end
          LOAD: begin
            led_q   <= init_pattern(mode_q);
            dir_q   <= 1'b1;
            state_q <= pause ? HOLD : RUN;
          end
          RUN: begin
            if (adv) begin
              tick_q <= 1'b1;
              if (req) begin
                ack_q  <= 1'b1;
                mode_q <= mode_t'(mode_if.mode_sel);
                led_q  <= init_pattern(mode_t'(mode_if.mode_sel));
                dir_q  <= 1'b1;
              end else begin
                led_q <= nxt.led;
                dir_q <= nxt.dir;
              end
            end
            if (pause) state_q <= HOLD;
          end
          HOLD: begin
            if (req) begin
              ack_q  <= 1'b1;
              mode_q <= mode_t'(mode_if.mode_sel);
              led_q  <= init_pattern(mode_t'(mode_if.mode_sel));
              dir_q  <= 1'b1;
            end else if (step) begin
              tick_q <= 1'b1;
              led_q  <= nxt.led;
              dir_q  <= nxt.dir;
            end
            if (!pause) state_q <= RUN;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign led_out          = led_q;
  assign tick             = tick_q;
  assign cur_mode         = mode_q;
  assign mode_if.mode_ack = ack_q;

endmodule

// File: doc/led_pattern_scheduler.md
Name: led_pattern_scheduler

Overview:
- Sequences the 8-bit LED output bank through one of four selectable animation patterns, at a programmable tick rate derived from clk.
- Replaces the single fixed shift sequence with a controller that owns the prescaler, the pattern state and mode switching.
- Mode changes use a valid/ack handshake and take effect only on tick boundaries, so patterns never tear.
- Sits between the user input pins (mode/speed/pause/step) and the dedicated LED outputs.

Parameters:
- TICK_DIV, 24'd10_000_000, base clk cycles per pattern step at speed 0 (1 s at 10 MHz).
- LED_W, 8, LED bank width; patterns are defined for 8 only.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  design enable; low forces IDLE
- mode_sel  input  2  requested pattern: 0 CHASE, 1 BOUNCE, 2 FILL, 3 BLINK
- mode_valid  input  1  mode request; held until mode_ack
- mode_ack  output  1  one-cycle pulse: request accepted
- speed  input  3  period = max(TICK_DIV >> speed, 1) cycles
- pause  input  1  level; suppresses ticks
- step  input  1  pulse; advances one step while paused
- led_out  output  8  current pattern
- tick  output  1  one-cycle pulse on every pattern advance
- cur_mode  output  2  active pattern

Behaviour:
- Reset (async, rst_n low):
  - led_out=0x00, tick=0, mode_ack=0, cur_mode=0.
  - Prescaler count=0, period register=max(TICK_DIV,1), bounce direction=up, state=IDLE.
- Prescaler:
  - count runs 0..period-1.
  - Terminal count (count==period-1) in RUN produces an advance event.
  - period is re-latched from speed only at wrap, or on entry to RUN; a mid-period speed change is ignored until the next wrap.
  - TICK_DIV>>speed == 0 clamps to 1, giving an advance every cycle.
- States:
  - IDLE
    - Entered from reset, or when ena is low (from any state).
    - led_out=0x00, count held at 0, no ticks.
    - mode_valid is accepted the next cycle: ack and cur_mode update.
    - ena high: next cycle goes to LOAD.
  - LOAD
    - One cycle; led_out gets the initial pattern of cur_mode; count=0.
    - Next state is RUN if pause is low, otherwise HOLD.
  - RUN
    - On an advance event, at that edge: tick=1 and led_out advances, both visible the next cycle.
    - Pending mode_valid is accepted on an advance event instead of advancing. At that edge: mode_ack=1, cur_mode=mode_sel, led_out=initial pattern of the new mode, tick=1.
    - pause high: next cycle goes to HOLD with count frozen.
  - HOLD
    - No advance events; count frozen.
    - step: the next edge advances one step with tick=1.
    - mode_valid: the next edge accepts it (ack plus load).
    - mode_valid and step in the same cycle: the mode load wins and step is dropped.
    - pause low: returns to RUN, resuming count.
- Initial patterns and step rules:
  - CHASE: init 0x01; rotate left (0x80 -> 0x01).
  - BOUNCE: init 0x01, dir up; shift toward the MSB, reverse at 0x80 and at 0x01.
    - Sequence: 01,02,…,80,40,…,01,02 (period 14).
  - FILL: init 0x00; led=(led<<1)|1; 0xFF -> 0x00 (period 9).
  - BLINK: init 0xFF; invert each step.
- Mode requests:
  - A request equal to cur_mode is still acked, and the pattern restarts.
  - mode_ack is never asserted twice for one held request. mode_valid must drop the cycle after ack; a still-high mode_valid on the following cycle is treated as a new request.
- Reset or ena drop mid-period discards the count and any pending request without an ack.

Decomposition:
- Package led_sched_pkg:
  - mode enum (CHASE/BOUNCE/FILL/BLINK)
  - state enum (IDLE/LOAD/RUN/HOLD)
  - per-mode initial-pattern constants
  - next-pattern function (mode, led, dir)
- Sub-module tick_prescaler:
  - Inputs: run, speed, TICK_DIV.
  - Outputs: one-cycle advance event.
  - Owns the period latch and the clamp.

Test Plan:
- TICK_DIV=16, speed=0, CHASE, ena=1:
  - LOAD gives led=0x01.
  - tick every 16 cycles; led reads 02,04,…,80,01.
  - Exactly 8 ticks per full cycle.
- BOUNCE, speed=2 (period 4):
  - led sequence 01,02,…,80,40,…,01,02, period 14.
  - No 0x80 or 0x01 repeated back-to-back.
- FILL running; raise mode_valid with mode_sel=3 mid-period:
  - mode_ack fires at the next advance edge only, with led=0xFF and cur_mode=3.
  - Next tick gives led=0x00.
- pause=1 in CHASE at led=0x04:
  - No tick for 100 cycles.
  - step pulse: one tick, led=0x08.
  - step plus mode_valid (mode_sel=2) together: led=0x00 and ack, no shift.
- speed changed 0->7 mid-period:
  - Current period completes at 16 cycles, then period=1 (tick every cycle, clamped).
- Boundary scenario:
  - Part 1: assert rst_n low asynchronously mid-period.
    - Outputs zero immediately with no clock.
  - Part 2: run for a while, then drop ena with a request pending.
    - led=0x00, no ack.
  - Part 3: raise ena again.
    - LOAD restarts cur_mode from its initial pattern.
